bp_update_scheduler: RTL and testbench
======================================

BP_UPDATE_SCHEDULER -- requirements
Module: bp_update_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: update FIFO entries; power of two, 2..16.
REQ-002 Parameter IDX_W, default 4: predictor table index width; tables hold 2^IDX_W entries.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port upd_valid  input  1  EX stage offers a resolved branch update.
REQ-006 Port upd_index  input  IDX_W  pc[IDX_W+1:2] of the resolved branch.
REQ-007 Port upd_ghr  input  IDX_W  global history snapshot taken at prediction time.
REQ-008 Port upd_taken  input  1  resolved direction, 1 = taken.
REQ-009 Port upd_ready  output  1  scheduler accepts an update this cycle.
REQ-010 Port tbl_busy  input  1  predictor table port is in use by a lookup; no write may issue.
REQ-011 Port flush_tables  input  1  request to clear all predictor tables.
REQ-012 Port wr_en  output  1  table write strobe, one entry per cycle.
REQ-013 Port wr_local_idx  output  IDX_W  local (BHT) write index.
REQ-014 Port wr_global_idx  output  IDX_W  global (PHT) write index.
REQ-015 Port wr_taken  output  1  direction used to step the 2-bit counters.
REQ-016 Port wr_clear  output  1  write forces counters to 2'b01 instead of stepping.
REQ-017 Port init_busy  output  1  table clear sweep in progress.
REQ-018 Port pending  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-019 Port drop_count  output  8  number of updates offered while upd_ready was low; saturating.

Function
REQ-020 FSM states: CLEAR and RUN; no other states.
REQ-021 CLEAR: sweep counter i from 0 to 2^IDX_W-1, one step per cycle; tbl_busy is ignored.
REQ-022 CLEAR outputs: wr_en=1, wr_clear=1, wr_local_idx=wr_global_idx=i, wr_taken=0, init_busy=1, upd_ready=0.
REQ-023 CLEAR -> RUN in the cycle after i = 2^IDX_W-1 is written; the sweep counter then returns to 0.
REQ-024 RUN: upd_ready = !(pending == DEPTH), independent of a same-cycle pop.
REQ-025 Push when upd_valid && upd_ready; the entry stores {upd_index, upd_index ^ upd_ghr, upd_taken}.
REQ-026 RUN write: wr_en = (pending != 0) && !tbl_busy, with wr_clear=0 and all fields taken from the FIFO head; head pops in the same cycle.
REQ-027 No bypass: an update pushed in cycle N reaches wr_en no earlier than cycle N+1; ordering is strict FIFO.
REQ-028 A simultaneous push and pop leaves pending unchanged; the FIFO pointers wrap modulo DEPTH.
REQ-029 When wr_en=0, the write fields SHALL be driven to 0.
REQ-030 upd_valid with upd_ready=0 (full, or CLEAR): the update is discarded and drop_count increments, saturating at 255.
REQ-031 flush_tables in RUN: the FIFO empties (pending=0) and the FSM enters CLEAR at i=0 next cycle; a same-cycle push or pop is discarded.
REQ-032 flush_tables during CLEAR restarts the sweep at i=0 next cycle.
REQ-033 drop_count is not cleared by flush_tables.

Reset
REQ-034 While rst_n=0 at a clock edge: state<=CLEAR, i<=0, FIFO empty, drop_count<=0.
REQ-035 While rst_n is low, outputs SHALL be wr_en=0, upd_ready=0, init_busy=1, pending=0, drop_count=0, and all write fields 0.
REQ-036 Reset asserted mid-sweep or with a non-empty FIFO discards all state; nothing is written after rst_n rises except the new sweep.
REQ-037 First cycle after rst_n rises: CLEAR writes index 0.

Verification
REQ-038 Reset release, defaults, no stimulus -> wr_en=1 and wr_clear=1 for 16 cycles (idx 0..15), then init_busy=0 and upd_ready=1 on cycle 17.
REQ-039 RUN, tbl_busy=0, push idx=5, ghr=3, taken=1 -> next cycle wr_en=1, wr_local_idx=5, wr_global_idx=6, wr_taken=1; pending returns to 0.
REQ-040 tbl_busy=1, 5 pushes on consecutive cycles -> 4 accepted, pending=4, upd_ready=0, drop_count=1; release tbl_busy -> 4 writes in push order on consecutive cycles.
REQ-041 pending=DEPTH, tbl_busy=0, upd_valid held -> one pop per cycle; upd_ready becomes 1 the cycle after the first pop; order preserved across pointer wrap.
REQ-042 flush_tables with pending=3 -> pending=0 next cycle, 16-cycle clear sweep, queued entries never written; flush_tables at sweep i=9 -> sweep restarts at 0.
REQ-043 300 updates offered while in CLEAR -> drop_count=255 and no update is written.

Source files
------------

// File: rtl/bp_update_scheduler_if.sv
// Update/write bundle between the EX stage, the scheduler and the predictor tables.
// The master side offers branch updates and controls the table port; the slave side is the scheduler.
interface bp_update_scheduler_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
);
  logic                     upd_valid;
  logic [IDX_W-1:0]         upd_index;
  logic [IDX_W-1:0]         upd_ghr;
  logic                     upd_taken;
  logic                     upd_ready;
  logic                     tbl_busy;
  logic                     flush_tables;
  logic                     wr_en;
  logic [IDX_W-1:0]         wr_local_idx;
  logic [IDX_W-1:0]         wr_global_idx;
  logic                     wr_taken;
  logic                     wr_clear;
  logic                     init_busy;
  logic [$clog2(DEPTH):0]   pending;
  logic [7:0]               drop_count;

  modport master (
    output upd_valid, upd_index, upd_ghr, upd_taken, tbl_busy, flush_tables,
    input  upd_ready, wr_en, wr_local_idx, wr_global_idx, wr_taken, wr_clear,
           init_busy, pending, drop_count
  );

  modport slave (
    input  upd_valid, upd_index, upd_ghr, upd_taken, tbl_busy, flush_tables,
    output upd_ready, wr_en, wr_local_idx, wr_global_idx, wr_taken, wr_clear,
           init_busy, pending, drop_count
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Queues resolved branch updates and drains them into the predictor tables when the port is free.
// After reset or a flush, a CLEAR sweep resets every counter before updates are accepted.
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  bp_update_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 * IDX_W + 1;
  localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};
  localparam logic [PTR_W:0]   FULL       = (PTR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_sweep, w_sweep_next;
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_drop;
  logic             w_ready, w_push, w_pop, w_drop, w_flush_run;
  logic [ENT_W-1:0] w_head, w_entry;

  // Entry layout: {local index, global (gshare) index, direction}.
  assign w_entry = {bus.upd_index, bus.upd_index ^ bus.upd_ghr, bus.upd_taken};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_drop  = bus.upd_valid && !w_ready;
  assign w_flush_run = (r_state == RUN) && bus.flush_tables;

  assign bus.upd_ready  = w_ready;
  assign bus.pending    = rst_n ? r_count : '0;
  assign bus.drop_count = rst_n ? r_drop : '0;

  always_comb begin
    w_state_next      = r_state;
    w_sweep_next      = r_sweep;
    w_ready           = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    bus.wr_en         = 1'b0;
    bus.wr_clear      = 1'b0;
    bus.wr_local_idx  = '0;
    bus.wr_global_idx = '0;
    bus.wr_taken      = 1'b0;
    bus.init_busy     = 1'b1;
    if (rst_n) begin
      case (r_state)
        CLEAR: begin
          bus.wr_en         = 1'b1;
          bus.wr_clear      = 1'b1;
          bus.wr_local_idx  = r_sweep;
          bus.wr_global_idx = r_sweep;
          if (bus.flush_tables) begin
            w_sweep_next = '0;
          end else if (r_sweep == SWEEP_LAST) begin
            w_state_next = RUN;
            w_sweep_next = '0;
          end else begin
            w_sweep_next = r_sweep + 1'b1;
          end
        end
        RUN: begin
          bus.init_busy = 1'b0;
          w_ready       = (r_count != FULL);
          if (bus.flush_tables) begin
            // Queued entries are abandoned: the tables are about to be wiped anyway.
            w_state_next = CLEAR;
            w_sweep_next = '0;
          end else begin
            w_push = bus.upd_valid && w_ready;
            w_pop  = (r_count != '0) && !bus.tbl_busy;
            if (w_pop) begin
              bus.wr_en         = 1'b1;
              bus.wr_local_idx  = w_head[ENT_W-1 -: IDX_W];
              bus.wr_global_idx = w_head[IDX_W:1];
              bus.wr_taken      = w_head[0];
            end
          end
        end
        default: begin
          w_state_next = CLEAR;
          w_sweep_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= CLEAR;
      r_sweep  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sweep <= w_sweep_next;
      if (w_flush_run) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
    end
  end

  // Storage has no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Self-checking bench: table vectors plus directed sequences, all checked through a
// per-cycle scoreboard of expected table writes.
module tb_bp_update_scheduler;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;

  typedef struct packed {
    logic [3:0] l;
    logic [3:0] g;
    logic       t;
  } wr_t;

  typedef struct {
    logic [3:0] idx;
    logic [3:0] ghr;
    logic       tk;
    logic [3:0] exp_l;
    logic [3:0] exp_g;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic m_clear;
  logic [3:0] m_sweep;
  int   m_drop;
  wr_t  sb[$];
  vec_t vecs[8];

  bp_update_scheduler_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) b ();

  bp_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic v, input logic [3:0] idx, input logic [3:0] ghr,
                       input logic tk, input logic busy, input logic fl,
                       input logic [3:0] el, input logic [3:0] eg);
    bit  exp_ready;
    bit  exp_wr;
    wr_t e;
    b.upd_valid    = v;
    b.upd_index    = idx;
    b.upd_ghr      = ghr;
    b.upd_taken    = tk;
    b.tbl_busy     = busy;
    b.flush_tables = fl;
    #1;
    exp_ready = 1'b0;
    if (m_clear) begin
      chk("clr_init_busy", int'(b.init_busy), 1);
      chk("clr_wr_en", int'(b.wr_en), 1);
      chk("clr_wr_clear", int'(b.wr_clear), 1);
      chk("clr_local_idx", int'(b.wr_local_idx), int'(m_sweep));
      chk("clr_global_idx", int'(b.wr_global_idx), int'(m_sweep));
      chk("clr_taken", int'(b.wr_taken), 0);
      chk("clr_ready", int'(b.upd_ready), 0);
      chk("clr_pending", int'(b.pending), 0);
    end else begin
      exp_ready = (sb.size() != DEPTH);
      exp_wr    = (sb.size() != 0) && !busy && !fl;
      chk("run_init_busy", int'(b.init_busy), 0);
      chk("pending", int'(b.pending), sb.size());
      chk("upd_ready", int'(b.upd_ready), int'(exp_ready));
      chk("wr_en", int'(b.wr_en), int'(exp_wr));
      chk("wr_clear", int'(b.wr_clear), 0);
      if (exp_wr) begin
        e = sb.pop_front();
        $display("write local=%0d global=%0d taken=%0d", b.wr_local_idx, b.wr_global_idx, b.wr_taken);
        chk("wr_local_idx", int'(b.wr_local_idx), int'(e.l));
        chk("wr_global_idx", int'(b.wr_global_idx), int'(e.g));
        chk("wr_taken", int'(b.wr_taken), int'(e.t));
      end else begin
        chk("idle_fields", int'({b.wr_local_idx, b.wr_global_idx, b.wr_taken}), 0);
      end
    end
    chk("drop_count", int'(b.drop_count), m_drop);
    if (v && !exp_ready && m_drop < 255) m_drop++;
    if (fl) begin
      sb.delete();
      m_clear = 1'b1;
      m_sweep = 4'd0;
    end else if (m_clear) begin
      if (m_sweep == 4'd15) m_clear = 1'b0;
      m_sweep = m_sweep + 4'd1;
    end else if (v && exp_ready) begin
      sb.push_back('{l: el, g: eg, t: tk});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [3:0] idx, input logic [3:0] ghr,
                       input logic tk, input logic busy, input logic fl);
    cycle(v, idx, ghr, tk, busy, fl, idx, idx ^ ghr);
  endtask

  task automatic idle(input int n, input logic busy);
    for (int k = 0; k < n; k++) offer(1'b0, 4'd0, 4'd0, 1'b0, busy, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    b.upd_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_wr_en", int'(b.wr_en), 0);
      chk("rst_ready", int'(b.upd_ready), 0);
      chk("rst_init_busy", int'(b.init_busy), 1);
      chk("rst_pending", int'(b.pending), 0);
      chk("rst_drop", int'(b.drop_count), 0);
      chk("rst_fields", int'({b.wr_local_idx, b.wr_global_idx, b.wr_taken, b.wr_clear}), 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    sb.delete();
    m_clear = 1'b1;
    m_sweep = 4'd0;
    m_drop  = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_clear = 1'b1;
    m_sweep = 4'd0;
    m_drop  = 0;
    rst_n = 1'b0;
    b.upd_valid = 1'b0; b.upd_index = '0; b.upd_ghr = '0; b.upd_taken = 1'b0;
    b.tbl_busy = 1'b0; b.flush_tables = 1'b0;

    vecs[0] = '{idx: 4'd5,  ghr: 4'd3,  tk: 1'b1, exp_l: 4'd5,  exp_g: 4'd6};
    vecs[1] = '{idx: 4'd0,  ghr: 4'd0,  tk: 1'b0, exp_l: 4'd0,  exp_g: 4'd0};
    vecs[2] = '{idx: 4'd15, ghr: 4'd15, tk: 1'b1, exp_l: 4'd15, exp_g: 4'd0};
    vecs[3] = '{idx: 4'd10, ghr: 4'd5,  tk: 1'b0, exp_l: 4'd10, exp_g: 4'd15};
    vecs[4] = '{idx: 4'd9,  ghr: 4'd6,  tk: 1'b1, exp_l: 4'd9,  exp_g: 4'd15};
    vecs[5] = '{idx: 4'd7,  ghr: 4'd1,  tk: 1'b1, exp_l: 4'd7,  exp_g: 4'd6};
    vecs[6] = '{idx: 4'd8,  ghr: 4'd12, tk: 1'b0, exp_l: 4'd8,  exp_g: 4'd4};
    vecs[7] = '{idx: 4'd12, ghr: 4'd3,  tk: 1'b0, exp_l: 4'd12, exp_g: 4'd15};

    @(posedge clk);
    #1;
    do_reset(3);

    // Power-up sweep of 16 entries, then RUN.
    idle(16, 1'b0);
    idle(1, 1'b0);
    chk("run_after_sweep", int'(b.init_busy), 0);

    // Single updates from the vector table: each written the cycle after its push.
    foreach (vecs[k]) begin
      cycle(1'b1, vecs[k].idx, vecs[k].ghr, vecs[k].tk, 1'b0, 1'b0, vecs[k].exp_l, vecs[k].exp_g);
      idle(1, 1'b0);
    end

    // Table port busy: 5 offers, 4 accepted, 1 dropped; then drain in order.
    for (int k = 0; k < 5; k++) offer(1'b1, 4'(k + 1), 4'(k * 3), 1'(k), 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b0);

    // Full FIFO with upd_valid held: one pop per cycle, order kept across wrap.
    for (int k = 0; k < 4; k++) offer(1'b1, 4'(k + 8), 4'(k), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) offer(1'b1, 4'(k), 4'(15 - k), 1'(k), 1'b0, 1'b0);
    idle(5, 1'b0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 60; k++)
      offer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 1 : 0), 1'b0);
    idle(6, 1'b0);

    // Flush with pending=3; queued entries must never be written.
    for (int k = 0; k < 3; k++) offer(1'b1, 4'(k + 2), 4'd1, 1'b1, 1'b1, 1'b0);
    offer(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(9, 1'b0);
    chk("sweep_at_9", int'(b.wr_local_idx), 9);
    offer(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    idle(17, 1'b0);

    // 300 offers while clearing: all dropped, counter saturates.
    offer(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++)
      offer(1'b1, 4'(k), 4'(k >> 4), 1'(k), 1'b0, (k % 15) == 14 ? 1'b1 : 1'b0);
    chk("drop_saturated", int'(b.drop_count), 255);
    idle(17, 1'b0);
    chk("drop_kept", int'(b.drop_count), 255);

    // Reset with a non-empty FIFO, then reset mid-sweep.
    for (int k = 0; k < 2; k++) offer(1'b1, 4'(k + 3), 4'd7, 1'b1, 1'b1, 1'b0);
    do_reset(2);
    idle(7, 1'b0);
    do_reset(1);
    idle(17, 1'b0);
    for (int k = 0; k < 3; k++) offer(1'b1, 4'(k + 11), 4'(k), 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
